rename_alloc_stage: RTL and testbench
=====================================

Name: rename_alloc_stage

Overview:
- Single-issue register rename stage in the rcu; sits directly downstream of the physical-register freelist FIFO and upstream of ROB/dispatch.
- Reads the speculative RAT for sources, pops one free physical register per renamed destination, and updates the speculative RAT.
- Presents the renamed instruction in an output pipeline register with a valid/ready handshake.
- Maintains the architectural (committed) RAT; on flush, restores the speculative RAT from it.

Parameters:
- ARCH_REG_NUM, 32, number of architectural registers (x0..x31).
- ARCH_REG_WIDTH, 5, log2(ARCH_REG_NUM).
- PREG_WIDTH, 6, physical register index width; p0 is the hardwired zero register and is never allocated.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dec_valid_i  in  1  decoded instruction valid
- dec_ready_o  out  1  stage accepts instruction this cycle
- dec_rd_we_i  in  1  instruction writes rd
- dec_rd_i  in  ARCH_REG_WIDTH  architectural destination
- dec_rs1_i  in  ARCH_REG_WIDTH  architectural source 1
- dec_rs2_i  in  ARCH_REG_WIDTH  architectural source 2
- fl_rdata_i  in  PREG_WIDTH  freelist head entry
- fl_empty_i  in  1  freelist empty
- fl_rd_en_o  out  1  pop freelist head
- ren_valid_o  out  1  renamed instruction valid
- ren_ready_i  in  1  downstream accepts
- ren_rd_we_o  out  1  allocation performed
- ren_prs1_o  out  PREG_WIDTH  physical source 1
- ren_prs2_o  out  PREG_WIDTH  physical source 2
- ren_prd_o  out  PREG_WIDTH  newly allocated physical destination (0 if no alloc)
- ren_old_prd_o  out  PREG_WIDTH  previous mapping of rd, for release at commit
- commit_valid_i  in  1  committing instruction with allocation
- commit_rd_i  in  ARCH_REG_WIDTH  committed architectural rd
- commit_prd_i  in  PREG_WIDTH  committed physical rd
- flush_i  in  1  pipeline flush / mispredict recovery

Behaviour:
- Reset: both RATs all entries 0 (every arch reg maps to p0); ren_valid_o=0, all ren_* data outputs 0; fl_rd_en_o=0.
- need_alloc = dec_rd_we_i & (dec_rd_i != 0). Writes to x0 never allocate; ren_rd_we_o=0, ren_prd_o=0, ren_old_prd_o=0.
- dec_ready_o = !flush_i & (!ren_valid_o | ren_ready_i) & !(need_alloc & fl_empty_i). It must not depend on dec_valid_i.
- fire = dec_valid_i & dec_ready_o. fl_rd_en_o = fire & need_alloc (combinational; freelist head consumed at the same edge).
- Source lookup is combinational from the speculative RAT: prs = spec_rat[rs], with x0 always giving 0.
- On fire, at the clock edge:
  - Output register loads prs1, prs2, prd=fl_rdata_i, old_prd=spec_rat[rd].
  - spec_rat[rd] <= fl_rdata_i.
  - Latency is 1 cycle, decode to ren_valid_o.
- Back-to-back dependence (I1 writes x5, I2 reads x5 next cycle): the RAT is already updated at the edge, so no bypass path is needed. Same-instruction rs==rd reads the OLD mapping.
- Output handshake:
  - ren_valid_o clears when ren_ready_i & !fire.
  - Data holds stable while ren_valid_o & !ren_ready_i.
  - Full throughput of 1 instruction/cycle when the downstream is always ready.
- Commit: commit_valid_i & commit_rd_i!=0 writes arch_rat[commit_rd_i] <= commit_prd_i. Commit does not touch spec_rat.
- Flush (priority over fire):
  - ren_valid_o <= 0.
  - spec_rat <= arch_rat with the same-cycle commit write forwarded in.
  - No freelist pop.
  - Freelist pointer recovery is owned by the freelist/ROB logic, not this block.
- Freelist empty with need_alloc: stall (dec_ready_o=0). Instructions without rd still proceed.
- Reset mid-operation: in-flight output is dropped and all RAT state returns to 0 the next cycle.

Decomposition:
- Shared rcu package: ARCH_REG_WIDTH, PREG_WIDTH constants, and a renamed-instruction struct (rd_we, prs1, prs2, prd, old_prd).
- One natural sub-module: rat_regfile (ARCH_REG_NUM x PREG_WIDTH, 2 comb read ports plus 1 old-prd read, 1 write, bulk-load port). It is instantiated twice, as spec and arch; the arch instance needs 1 write only.

Test Plan:
- Reset, then issue "x5 <- x1,x2" with fl_rdata_i=7 -> fl_rd_en_o=1 same cycle; next cycle ren_valid_o=1, prs1=0, prs2=0, prd=7, old_prd=0.
- Follow-up "x6 <- x5,x5" back-to-back with fl_rdata_i=8 -> prs1=prs2=7, prd=8, old_prd=0; then "x5 <- x5" with fl=9 -> prs1=7, prd=9, old_prd=7.
- Write to x0 with fl_empty_i=1 -> accepted, fl_rd_en_o=0, ren_rd_we_o=0, prd=0; write to x3 with fl_empty_i=1 -> dec_ready_o=0 until fl_empty_i drops.
- Hold ren_ready_i=0 for 3 cycles with output valid -> dec_ready_o=0, ren_* outputs stable, no freelist pops.
- Commit x5->p7, rename x5->p9, then flush with commit x6->p8 in the same cycle -> ren_valid_o=0; a subsequent read of x5 gives 7, of x6 gives 8.
- Flush asserted together with dec_valid_i -> dec_ready_o=0, fl_rd_en_o=0, spec RAT equals arch RAT.

Source files
------------

// File: rtl/rename_alloc_stage_pkg.sv
// Shared rcu rename types: register index widths and the renamed bundle.
package rename_alloc_stage_pkg;

  localparam int ARCH_REG_NUM   = 32;
  localparam int ARCH_REG_WIDTH = 5;
  localparam int PREG_WIDTH     = 6;

  typedef logic [ARCH_REG_WIDTH-1:0] areg_t;
  typedef logic [PREG_WIDTH-1:0]     preg_t;
  typedef preg_t [ARCH_REG_NUM-1:0]  rat_t;

  typedef struct packed {
    logic  rd_we;
    preg_t prs1;
    preg_t prs2;
    preg_t prd;
    preg_t old_prd;
  } ren_instr_t;

  function automatic logic is_x0(areg_t r);
    return r == '0;
  endfunction

endpackage

// File: rtl/rename_alloc_stage_if.sv
// Decode, freelist, rename-out, commit and flush signals of the rename stage.
interface rename_alloc_stage_if;
  import rename_alloc_stage_pkg::*;

  logic  dec_valid_i;
  logic  dec_ready_o;
  logic  dec_rd_we_i;
  areg_t dec_rd_i;
  areg_t dec_rs1_i;
  areg_t dec_rs2_i;

  preg_t fl_rdata_i;
  logic  fl_empty_i;
  logic  fl_rd_en_o;

  logic  ren_valid_o;
  logic  ren_ready_i;
  logic  ren_rd_we_o;
  preg_t ren_prs1_o;
  preg_t ren_prs2_o;
  preg_t ren_prd_o;
  preg_t ren_old_prd_o;

  logic  commit_valid_i;
  areg_t commit_rd_i;
  preg_t commit_prd_i;
  logic  flush_i;

  modport slave (
    input  dec_valid_i, dec_rd_we_i,
    input  dec_rd_i, dec_rs1_i, dec_rs2_i,
    output dec_ready_o,
    input  fl_rdata_i, fl_empty_i,
    output fl_rd_en_o,
    output ren_valid_o, ren_rd_we_o,
    output ren_prs1_o, ren_prs2_o,
    output ren_prd_o, ren_old_prd_o,
    input  ren_ready_i,
    input  commit_valid_i, commit_rd_i,
    input  commit_prd_i, flush_i
  );

  modport master (
    output dec_valid_i, dec_rd_we_i,
    output dec_rd_i, dec_rs1_i, dec_rs2_i,
    input  dec_ready_o,
    output fl_rdata_i, fl_empty_i,
    input  fl_rd_en_o,
    input  ren_valid_o, ren_rd_we_o,
    input  ren_prs1_o, ren_prs2_o,
    input  ren_prd_o, ren_old_prd_o,
    output ren_ready_i,
    output commit_valid_i, commit_rd_i,
    output commit_prd_i, flush_i
  );

endinterface

// File: rtl/rename_alloc_stage_rat_regfile.sv
// Register alias table: 3 comb reads, 1 write, bulk load (load wins).
module rat_regfile
  import rename_alloc_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  areg_t rs1_i,
  input  areg_t rs2_i,
  input  areg_t rd_i,
  output preg_t prs1_o,
  output preg_t prs2_o,
  output preg_t old_prd_o,
  input  logic  we_i,
  input  areg_t waddr_i,
  input  preg_t wdata_i,
  input  logic  load_i,
  input  rat_t  load_data_i,
  output rat_t  tbl_o
);

  rat_t tbl_q;
  rat_t tbl_d;

  always_comb begin
    tbl_d = tbl_q;
    if (load_i) begin
      tbl_d = load_data_i;
    end else if (we_i && !is_x0(waddr_i)) begin
      tbl_d[waddr_i] = wdata_i;
    end
    // x0 stays pinned to p0 whatever is loaded
    tbl_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_q <= '0;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  assign prs1_o    = is_x0(rs1_i) ? '0 : tbl_q[rs1_i];
  assign prs2_o    = is_x0(rs2_i) ? '0 : tbl_q[rs2_i];
  assign old_prd_o = is_x0(rd_i)  ? '0 : tbl_q[rd_i];
  assign tbl_o     = tbl_q;

endmodule

// File: rtl/rename_alloc_stage.sv
// Single-issue rename: spec RAT lookup, freelist pop, output register,
// architectural RAT tracking and flush recovery.
module rename_alloc_stage
  import rename_alloc_stage_pkg::*;
(
  input logic           clk,
  input logic           rst,
  rename_alloc_stage_if.slave bus
);

  logic       need_alloc;
  logic       fire;
  logic       commit_we;
  preg_t      prs1;
  preg_t      prs2;
  preg_t      old_prd;
  rat_t       arch_tbl;
  rat_t       arch_fwd;
  rat_t       spec_tbl_unused;
  preg_t      arch_prs1_unused;
  preg_t      arch_prs2_unused;
  preg_t      arch_old_unused;
  logic       valid_q;
  logic       valid_d;
  ren_instr_t out_q;
  ren_instr_t out_d;

  assign need_alloc = bus.dec_rd_we_i & ~is_x0(bus.dec_rd_i);

  assign bus.dec_ready_o = ~rst & ~bus.flush_i
                         & (~valid_q | bus.ren_ready_i)
                         & ~(need_alloc & bus.fl_empty_i);

  assign fire           = bus.dec_valid_i & bus.dec_ready_o;
  assign bus.fl_rd_en_o = fire & need_alloc;

  assign commit_we = bus.commit_valid_i
                   & ~is_x0(bus.commit_rd_i);

  // Recovery image includes the commit landing in the flush cycle
  always_comb begin
    arch_fwd = arch_tbl;
    if (commit_we) begin
      arch_fwd[bus.commit_rd_i] = bus.commit_prd_i;
    end
  end

  rat_regfile u_spec_rat (
    .clk         (clk),
    .rst         (rst),
    .rs1_i       (bus.dec_rs1_i),
    .rs2_i       (bus.dec_rs2_i),
    .rd_i        (bus.dec_rd_i),
    .prs1_o      (prs1),
    .prs2_o      (prs2),
    .old_prd_o   (old_prd),
    .we_i        (bus.fl_rd_en_o),
    .waddr_i     (bus.dec_rd_i),
    .wdata_i     (bus.fl_rdata_i),
    .load_i      (bus.flush_i),
    .load_data_i (arch_fwd),
    .tbl_o       (spec_tbl_unused)
  );

  rat_regfile u_arch_rat (
    .clk         (clk),
    .rst         (rst),
    .rs1_i       ('0),
    .rs2_i       ('0),
    .rd_i        ('0),
    .prs1_o      (arch_prs1_unused),
    .prs2_o      (arch_prs2_unused),
    .old_prd_o   (arch_old_unused),
    .we_i        (commit_we),
    .waddr_i     (bus.commit_rd_i),
    .wdata_i     (bus.commit_prd_i),
    .load_i      (1'b0),
    .load_data_i ('0),
    .tbl_o       (arch_tbl)
  );

  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    if (bus.flush_i) begin
      valid_d = 1'b0;
    end else if (fire) begin
      valid_d       = 1'b1;
      out_d.rd_we   = need_alloc;
      out_d.prs1    = prs1;
      out_d.prs2    = prs2;
      out_d.prd     = need_alloc ? bus.fl_rdata_i : '0;
      out_d.old_prd = need_alloc ? old_prd : '0;
    end else if (bus.ren_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign bus.ren_valid_o   = valid_q;
  assign bus.ren_rd_we_o   = out_q.rd_we;
  assign bus.ren_prs1_o    = out_q.prs1;
  assign bus.ren_prs2_o    = out_q.prs2;
  assign bus.ren_prd_o     = out_q.prd;
  assign bus.ren_old_prd_o = out_q.old_prd;

endmodule

// File: tb/tb_rename_alloc_stage.sv
// Bench for rename_alloc_stage: vector table, corner sequences,
// then random traffic against a map-based reference model.
module tb_rename_alloc_stage;
  import rename_alloc_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 clk = ~clk;

  rename_alloc_stage_if bus ();

  rename_alloc_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic we;
    int   rd, rs1, rs2, fl;
    logic empty;
    logic e_flrd, e_we;
    int   e_prs1, e_prs2, e_prd, e_old;
  } vec_t;

  vec_t vt[5];

  // reference model state
  int   m_spec[32];
  int   m_arch[32];
  logic m_v;
  logic m_we;
  int   m_p1, m_p2, m_pd, m_old;

  task automatic chk(string nm, int act, int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.dec_valid_i    = 1'b0;
    bus.dec_rd_we_i    = 1'b0;
    bus.dec_rd_i       = '0;
    bus.dec_rs1_i      = '0;
    bus.dec_rs2_i      = '0;
    bus.fl_rdata_i     = '0;
    bus.fl_empty_i     = 1'b0;
    bus.ren_ready_i    = 1'b1;
    bus.commit_valid_i = 1'b0;
    bus.commit_rd_i    = '0;
    bus.commit_prd_i   = '0;
    bus.flush_i        = 1'b0;
  endtask

  task automatic issue(logic we, int rd, int rs1,
                       int rs2, int fl);
    bus.dec_valid_i = 1'b1;
    bus.dec_rd_we_i = we;
    bus.dec_rd_i    = areg_t'(rd);
    bus.dec_rs1_i   = areg_t'(rs1);
    bus.dec_rs2_i   = areg_t'(rs2);
    bus.fl_rdata_i  = preg_t'(fl);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_check();
    logic need, rdy;
    need = bus.dec_rd_we_i && bus.dec_rd_i != 0;
    rdy  = !bus.flush_i && (!m_v || bus.ren_ready_i)
         && !(need && bus.fl_empty_i);
    chk("rnd_ready", bus.dec_ready_o, rdy);
    chk("rnd_flrd", bus.fl_rd_en_o,
        bus.dec_valid_i && rdy && need);
    chk("rnd_valid", bus.ren_valid_o, m_v);
    if (m_v) begin
      chk("rnd_we", bus.ren_rd_we_o, m_we);
      chk("rnd_prs1", bus.ren_prs1_o, m_p1);
      chk("rnd_prs2", bus.ren_prs2_o, m_p2);
      chk("rnd_prd", bus.ren_prd_o, m_pd);
      chk("rnd_old", bus.ren_old_prd_o, m_old);
    end
  endtask

  task automatic model_step();
    logic need, fire;
    int   rd;
    rd   = bus.dec_rd_i;
    need = bus.dec_rd_we_i && rd != 0;
    fire = bus.dec_valid_i && !bus.flush_i
         && (!m_v || bus.ren_ready_i)
         && !(need && bus.fl_empty_i);
    if (bus.commit_valid_i && bus.commit_rd_i != 0)
      m_arch[bus.commit_rd_i] = bus.commit_prd_i;
    if (bus.flush_i) begin
      m_v = 1'b0;
      m_spec = m_arch;
    end else if (fire) begin
      m_v   = 1'b1;
      m_we  = need;
      m_p1  = m_spec[bus.dec_rs1_i];
      m_p2  = m_spec[bus.dec_rs2_i];
      m_pd  = need ? int'(bus.fl_rdata_i) : 0;
      m_old = need ? m_spec[rd] : 0;
      if (need) m_spec[rd] = bus.fl_rdata_i;
    end else if (bus.ren_ready_i) begin
      m_v = 1'b0;
    end
  endtask

  initial begin
    vt[0] = '{1, 5, 1, 2, 7, 0, 1, 1, 0, 0, 7, 0};
    vt[1] = '{1, 6, 5, 5, 8, 0, 1, 1, 7, 7, 8, 0};
    vt[2] = '{1, 5, 5, 0, 9, 0, 1, 1, 7, 0, 9, 7};
    vt[3] = '{1, 0, 6, 5, 11, 1, 0, 0, 8, 9, 0, 0};
    vt[4] = '{0, 7, 5, 6, 11, 1, 0, 0, 9, 8, 0, 0};

    idle();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_valid", bus.ren_valid_o, 0);
    chk("rst_prd", bus.ren_prd_o, 0);
    chk("rst_prs1", bus.ren_prs1_o, 0);
    chk("rst_flrd", bus.fl_rd_en_o, 0);

    foreach (vt[i]) begin
      issue(vt[i].we, vt[i].rd, vt[i].rs1,
            vt[i].rs2, vt[i].fl);
      bus.fl_empty_i = vt[i].empty;
      @(negedge clk);
      chk("vec_ready", bus.dec_ready_o, 1);
      chk("vec_flrd", bus.fl_rd_en_o, vt[i].e_flrd);
      tick();
      chk("vec_valid", bus.ren_valid_o, 1);
      chk("vec_we", bus.ren_rd_we_o, vt[i].e_we);
      chk("vec_prs1", bus.ren_prs1_o, vt[i].e_prs1);
      chk("vec_prs2", bus.ren_prs2_o, vt[i].e_prs2);
      chk("vec_prd", bus.ren_prd_o, vt[i].e_prd);
      chk("vec_old", bus.ren_old_prd_o, vt[i].e_old);
    end

    // empty freelist stalls an allocating instruction
    issue(1, 3, 0, 0, 12);
    bus.fl_empty_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("empty_ready", bus.dec_ready_o, 0);
      chk("empty_flrd", bus.fl_rd_en_o, 0);
      tick();
    end
    chk("empty_drain", bus.ren_valid_o, 0);
    bus.fl_empty_i = 1'b0;
    @(negedge clk);
    chk("refill_ready", bus.dec_ready_o, 1);
    chk("refill_flrd", bus.fl_rd_en_o, 1);
    tick();
    chk("refill_prd", bus.ren_prd_o, 12);
    chk("refill_old", bus.ren_old_prd_o, 0);

    // downstream backpressure holds the output
    bus.ren_ready_i = 1'b0;
    issue(1, 4, 3, 0, 13);
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", bus.dec_ready_o, 0);
      chk("bp_flrd", bus.fl_rd_en_o, 0);
      chk("bp_valid", bus.ren_valid_o, 1);
      chk("bp_prd", bus.ren_prd_o, 12);
      chk("bp_we", bus.ren_rd_we_o, 1);
      tick();
    end
    bus.ren_ready_i = 1'b1;
    bus.dec_valid_i = 1'b0;
    tick();
    chk("bp_release", bus.ren_valid_o, 0);

    // commit, rename, then flush with a same-cycle commit
    bus.commit_valid_i = 1'b1;
    bus.commit_rd_i    = 5;
    bus.commit_prd_i   = 7;
    tick();
    bus.commit_valid_i = 1'b0;
    issue(1, 5, 5, 0, 14);
    @(negedge clk);
    chk("pre_flush_flrd", bus.fl_rd_en_o, 1);
    tick();
    chk("pre_flush_old", bus.ren_old_prd_o, 9);
    chk("pre_flush_prs1", bus.ren_prs1_o, 9);
    issue(1, 5, 0, 0, 15);
    bus.flush_i        = 1'b1;
    bus.commit_valid_i = 1'b1;
    bus.commit_rd_i    = 6;
    bus.commit_prd_i   = 8;
    @(negedge clk);
    chk("flush_ready", bus.dec_ready_o, 0);
    chk("flush_flrd", bus.fl_rd_en_o, 0);
    tick();
    bus.flush_i        = 1'b0;
    bus.commit_valid_i = 1'b0;
    chk("flush_valid", bus.ren_valid_o, 0);
    issue(0, 0, 5, 6, 0);
    tick();
    chk("rec_x5", bus.ren_prs1_o, 7);
    chk("rec_x6", bus.ren_prs2_o, 8);
    issue(0, 0, 3, 4, 0);
    tick();
    chk("rec_x3", bus.ren_prs1_o, 0);
    chk("rec_x4", bus.ren_prs2_o, 0);

    // reset while an output is in flight
    issue(1, 5, 0, 0, 20);
    tick();
    chk("mid_valid", bus.ren_valid_o, 1);
    chk("mid_prd", bus.ren_prd_o, 20);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_flrd", bus.fl_rd_en_o, 0);
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", bus.ren_valid_o, 0);
    chk("mid_rst_prd", bus.ren_prd_o, 0);
    issue(0, 0, 5, 6, 0);
    tick();
    chk("mid_rst_x5", bus.ren_prs1_o, 0);
    chk("mid_rst_x6", bus.ren_prs2_o, 0);
    idle();
    tick();

    // randomized traffic against the reference model
    foreach (m_spec[i]) begin
      m_spec[i] = 0;
      m_arch[i] = 0;
    end
    m_v = 1'b0;
    m_we = 1'b0;
    m_p1 = 0;
    m_p2 = 0;
    m_pd = 0;
    m_old = 0;
    for (int c = 0; c < 400; c++) begin
      bus.dec_valid_i    = ($urandom_range(3) != 0);
      bus.dec_rd_we_i    = ($urandom_range(3) != 0);
      bus.dec_rd_i       = areg_t'($urandom_range(31));
      bus.dec_rs1_i      = areg_t'($urandom_range(31));
      bus.dec_rs2_i      = areg_t'($urandom_range(31));
      bus.fl_rdata_i     = preg_t'($urandom_range(63, 1));
      bus.fl_empty_i     = ($urandom_range(7) == 0);
      bus.ren_ready_i    = ($urandom_range(3) != 0);
      bus.commit_valid_i = ($urandom_range(2) == 0);
      bus.commit_rd_i    = areg_t'($urandom_range(31));
      bus.commit_prd_i   = preg_t'($urandom_range(63, 1));
      bus.flush_i        = ($urandom_range(15) == 0);
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_step();
      #1;
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
